// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding a downstream sequence detector.
// One active shift register plus a one-deep pending word for gapless streaming.
module bit_serializer #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_en,
  output logic             d_out,
  output logic             d_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] hold_q;
  logic             hold_v_q;
  logic [CW-1:0]    cnt_q;
  logic             accept;
  logic             last_bit;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on the pending slot and reset, never on in_valid.
  assign in_ready = !hold_v_q && !rst;
  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt_q == CNT_LAST);

  // Next shift value moves the register toward its output end by one bit.
  always_comb begin
    shreg_d = '0;
    if (LSB_FIRST) begin
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end else begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q <= in_data;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_en && last_bit) begin
            // Word completes here; chain the next one with no gap if available.
            cnt_q <= '0;
            if (hold_v_q) begin
              shreg_q  <= hold_q;
              hold_q   <= '0;
              hold_v_q <= 1'b0;
            end else if (accept) begin
              shreg_q <= in_data;
            end else begin
              shreg_q <= '0;
              state_q <= IDLE;
            end
          end else begin
            if (out_en) begin
              shreg_q <= shreg_d;
              cnt_q   <= cnt_q + 1'b1;
            end
            if (accept) begin
              hold_q   <= in_data;
              hold_v_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d_valid    = (state_q == SHIFT);
  assign d_out      = d_valid && (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]);
  assign word_start = d_valid && (cnt_q == '0);
  assign busy       = d_valid || hold_v_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: LSB-first instance for the main flow,
// plus an MSB-first instance for bit ordering.
module tb_bit_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_en;
  logic        d_out;
  logic        d_valid;
  logic        word_start;
  logic        busy;

  logic [15:0] m_in_data;
  logic        m_in_valid;
  logic        m_in_ready;
  logic        m_out_en;
  logic        m_d_out;
  logic        m_d_valid;
  logic        m_word_start;
  logic        m_busy;

  // Each entry is {word_start, d_out} expected for one stream bit.
  logic [1:0] exp_q[$];
  logic [1:0] m_q[$];

  int total = 0;
  int bad   = 0;
  int run_cur  = 0;
  int last_run = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(16), .LSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_en(out_en), .d_out(d_out), .d_valid(d_valid),
    .word_start(word_start), .busy(busy)
  );

  bit_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_data(m_in_data), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .out_en(m_out_en), .d_out(m_d_out), .d_valid(m_d_valid),
    .word_start(m_word_start), .busy(m_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] d);
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 0), d[i]});
  endtask

  // Holds in_valid until the word is taken; expectation is queued at the accept.
  task automatic send_word(input logic [15:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) push_word(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((d_valid || busy) && n < 300);
    check("idle_timeout", {31'd0, (n < 300)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && d_valid) begin
        run_cur++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL lsb_unexpected_bit: got d_out=%0b with no word pending", d_out);
        end else begin
          e = exp_q[0];
          check("lsb_bit", {30'd0, word_start, d_out}, {30'd0, e});
          if (out_en) void'(exp_q.pop_front());
        end
      end else begin
        if (run_cur > 0) last_run = run_cur;
        run_cur = 0;
      end
      if (!rst && m_d_valid) begin
        if (m_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL msb_unexpected_bit: got d_out=%0b with no word pending", m_d_out);
        end else begin
          e = m_q[0];
          check("msb_bit", {30'd0, m_word_start, m_d_out}, {30'd0, e});
          if (m_out_en) void'(m_q.pop_front());
        end
      end
    end
  endtask

  task automatic stimulus();
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_outs", {28'd0, d_out, d_valid, word_start, busy}, 32'd0);
    check("post_rst_in_ready", {30'd0, in_ready, m_in_ready}, 32'h3);
    @(posedge clk);
    #1;

    // Idle with garbage data and no valid: nothing emitted
    for (int i = 0; i < 6; i++) begin
      in_data = 16'($urandom_range(0, 65535));
      @(posedge clk);
      #1;
    end
    check("idle_ignore", {31'd0, d_valid}, 32'd0);

    // Single word, continuous enable, 1-cycle latency
    send_word(16'h000A);
    @(negedge clk);
    check("first_bit", {29'd0, d_valid, word_start, d_out}, 32'h6);
    wait_idle();
    check("single_run", last_run, 32'd16);
    check("single_busy", {31'd0, busy}, 32'd0);

    // Back-to-back words through the pending slot
    send_word(16'hA5A5);
    send_word(16'h0F0F);
    @(negedge clk);
    check("b2b_in_ready_low", {30'd0, in_ready, busy}, 32'h1);
    wait_idle();
    check("b2b_run", last_run, 32'd32);
    check("b2b_in_ready_back", {31'd0, in_ready}, 32'd1);

    // Stall every other cycle: each bit held two cycles
    out_en = 1'b0;
    send_word(16'h000A);
    for (int i = 0; i < 40; i++) begin
      out_en = (i % 2 == 1);
      @(posedge clk);
      #1;
    end
    out_en = 1'b1;
    wait_idle();
    check("stall_run", last_run, 32'd32);

    // Reset mid-word with a pending word: both discarded
    send_word(16'hFFFF);
    send_word(16'h1234);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_outs", {30'd0, d_valid, busy}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (20) @(negedge clk);
    check("midrst_silent", {31'd0, d_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Accept on the completing edge with hold empty: no gap
    send_word(16'h00FF);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    send_word(16'h0001);
    @(negedge clk);
    check("chain_first_bit", {29'd0, d_valid, word_start, d_out}, 32'h7);
    wait_idle();
    check("chain_run", last_run, 32'd32);

    // MSB-first instance: 16'h8000 -> 1 then fifteen 0s
    @(posedge clk);
    #1;
    m_in_valid = 1'b1;
    m_in_data  = 16'h8000;
    @(negedge clk);
    check("msb_in_ready", {31'd0, m_in_ready}, 32'd1);
    m_q.push_back(2'b11);
    for (int i = 1; i < 16; i++) m_q.push_back(2'b00);
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    m_in_data  = 16'hFFFF;
    @(negedge clk);
    check("msb_first_bit", {30'd0, m_d_valid, m_d_out}, 32'h3);
    repeat (20) @(negedge clk);
    check("msb_done", {30'd0, m_d_valid, m_busy}, 32'd0);

    check("lsb_queue_empty", exp_q.size(), 32'd0);
    check("msb_queue_empty", m_q.size(), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    out_en     = 1'b1;
    m_in_data  = '0;
    m_in_valid = 1'b0;
    m_out_en   = 1'b1;
    fork
      monitor();
      stimulus();
      begin
        repeat (5000) @(posedge clk);
        total++;
        bad++;
        $display("FAIL global_timeout: got 5000 cycles expected completion");
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
